// File: rtl/spi_cmd_ram.sv
// spi_cmd_ram: command-driven single-port RAM behind the SPI slave, with acknowledged read return.
// Optional macro SPI_RAM_AUTO_INC_EN enables post-access address auto-increment.
module spi_cmd_ram #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ack,
    output logic              addr_err
);
    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    localparam logic [ADDR_W:0] DEPTH = MEM_DEPTH[ADDR_W:0];

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [ADDR_W-1:0] addr_wr, addr_rd;
    logic [1:0]        op;
    logic              accept, wr_ok, rd_ok;

    assign op       = din[DATA_W+1:DATA_W];
    assign accept   = rx_valid && rx_ready;
    assign wr_ok    = {1'b0, addr_wr} < DEPTH;
    assign rd_ok    = {1'b0, addr_rd} < DEPTH;
    assign rx_ready = state == IDLE;
    assign tx_valid = state == HOLD;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [ADDR_W:0] LAST = DEPTH - 1'b1;
    // Out-of-range addresses also wrap to 0, so the address recovers into range.
    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= LAST) ? '0 : a + 1'b1;
    endfunction
`endif

    always_comb begin
        state_nx = state == IDLE ? ((accept && op == 2'b11) ? READ : IDLE) :
                   state == READ ? HOLD : (tx_ack ? IDLE : HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_wr  <= '0;
            addr_rd  <= '0;
            dout     <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nx;
            addr_err <= accept && ((op == 2'b01 && !wr_ok) || (op == 2'b11 && !rd_ok));
            if (accept && op == 2'b00) addr_wr <= din[ADDR_W-1:0];
            if (accept && op == 2'b10) addr_rd <= din[ADDR_W-1:0];
`ifdef SPI_RAM_AUTO_INC_EN
            if (accept && op == 2'b01) addr_wr <= inc(addr_wr);
`endif
            if (state == READ) begin
                dout <= rd_ok ? mem[addr_rd] : '0;
`ifdef SPI_RAM_AUTO_INC_EN
                addr_rd <= inc(addr_rd);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && op == 2'b01 && wr_ok) mem[addr_wr] <= din[DATA_W-1:0];
    end
endmodule

// File: tb/tb_spi_cmd_ram.sv
// tb_spi_cmd_ram: randomized command stream checked against a behavioural RAM model.
module tb_spi_cmd_ram;
    localparam int DEPTH = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic       tx_ack = 1'b0;
    logic       rx_ready, tx_valid, addr_err;
    logic [7:0] dout;

    int         n_tests = 0;
    int         n_fail = 0;
    int         m_wr = 0;
    int         m_rd = 0;
    logic [7:0] mm [256];

    spi_cmd_ram #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .dout(dout), .tx_valid(tx_valid), .tx_ack(tx_ack), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_addr(input int a);
`ifdef SPI_RAM_AUTO_INC_EN
        return a >= DEPTH - 1 ? 0 : a + 1;
`else
        return a;
`endif
    endfunction

    function automatic logic [7:0] rand_addr();
        return ($urandom_range(0, 9) == 0) ? 8'($urandom_range(DEPTH, 255)) : 8'($urandom_range(0, DEPTH - 1));
    endfunction

    // Non-read command, issued at a falling edge; returns at the next falling edge.
    task automatic cmd(input logic [1:0] op, input logic [7:0] v);
        din = {op, v};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("cmd_rx_ready", rx_ready, 1);
        if (op == 2'b01) begin
            check("wr_addr_err", addr_err, m_wr >= DEPTH);
            if (m_wr < DEPTH) mm[m_wr] = v;
            m_wr = next_addr(m_wr);
        end else begin
            check("cmd_addr_err", addr_err, 0);
            if (op == 2'b00) m_wr = v;
            else m_rd = v;
        end
    endtask

    task automatic read(input int delay, input bit drop, input bit ack_hi);
        logic [7:0] exp;
        bit         err;
        err = m_rd >= DEPTH;
        exp = err ? 8'h00 : mm[m_rd];
        m_rd = next_addr(m_rd);
        if (ack_hi) tx_ack = 1'b1;
        din = {2'b11, 8'($urandom)};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("rd_addr_err", addr_err, err);
        check("rd_busy_ready", rx_ready, 0);
        check("rd_busy_valid", tx_valid, 0);
        @(negedge clk);
        check("rd_err_clear", addr_err, 0);
        check("rd_valid", tx_valid, 1);
        check("rd_dout", dout, exp);
        check("rd_hold_ready", rx_ready, 0);
        if (ack_hi) begin
            @(negedge clk);
        end else begin
            repeat (delay) begin
                if (drop) begin
                    din = {2'($urandom), 8'($urandom)};
                    rx_valid = 1'b1;
                end
                @(negedge clk);
                rx_valid = 1'b0;
                check("hold_valid", tx_valid, 1);
                check("hold_ready", rx_ready, 0);
                check("hold_dout", dout, exp);
                check("hold_err", addr_err, 0);
            end
            tx_ack = 1'b1;
            @(negedge clk);
        end
        tx_ack = 1'b0;
        check("ack_valid", tx_valid, 0);
        check("ack_ready", rx_ready, 1);
        check("ack_dout_kept", dout, exp);
    endtask

    initial begin
        #1;
        check("rst_dout", dout, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_addr_err", addr_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tx_valid", tx_valid, 0);
        check("idle_rx_ready", rx_ready, 1);
        for (int a = 0; a < DEPTH; a++) begin
            cmd(2'b00, 8'(a));
            cmd(2'b01, 8'($urandom));
        end
        cmd(2'b00, 8'h12);
        cmd(2'b01, 8'hA5);
        cmd(2'b10, 8'h12);
        read(0, 1'b0, 1'b0);
        check("basic_A5", dout, 8'hA5);
        cmd(2'b10, 8'h12);
        read(5, 1'b1, 1'b0);
        cmd(2'b10, 8'h12);
        read(0, 1'b0, 1'b0);
        check("drop_kept_A5", dout, 8'hA5);
        cmd(2'b00, 8'hC8);
        cmd(2'b01, 8'h55);
        cmd(2'b10, 8'hC8);
        read(1, 1'b0, 1'b0);
        check("oob_dout", dout, 0);
        cmd(2'b10, 8'h12);
        read(0, 1'b0, 1'b1);
`ifdef SPI_RAM_AUTO_INC_EN
        cmd(2'b00, 8'hFF);
        cmd(2'b01, 8'h01);
        cmd(2'b01, 8'h02);
        cmd(2'b01, 8'h03);
        cmd(2'b10, 8'hFF);
        repeat (3) read(0, 1'b0, 1'b0);
`endif
        repeat (400) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 2) cmd(2'b00, rand_addr());
            else if (k < 5) cmd(2'b01, 8'($urandom));
            else if (k < 7) cmd(2'b10, rand_addr());
            else read($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
        end
        cmd(2'b00, 8'h05);
        cmd(2'b10, 8'h07);
        din = {2'b11, 8'h00};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrd_rst_valid", tx_valid, 0);
        check("midrd_rst_ready", rx_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_valid", tx_valid, 0);
        @(negedge clk);
        check("post_rst_valid2", tx_valid, 0);
        check("post_rst_ready", rx_ready, 1);
        check("post_rst_dout", dout, 0);
        m_wr = 0;
        m_rd = 0;
        read(0, 1'b0, 1'b0);
        cmd(2'b01, 8'h3C);
        cmd(2'b10, 8'h00);
        read(0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
